rx_serial_align: RTL and testbench

Receive-side serial-to-parallel front end of the lane PHY. It takes the 1-bit serial stream produced by the transmit serializer at clk_32f and finds byte alignment by hunting for the COM symbol. Once locked, it emits one parallel byte every 8 clocks with a valid flag, filtering COM and IDL symbols. Its outputs feed the receive-side byte un-striping and demux stage.

---
 rtl/phy_pkg.sv | 19 +
 rtl/rx_shift8.sv | 26 ++
 rtl/rx_serial_align.sv | 141 ++++++++++++++
 tb/tb_rx_serial_align.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared lane-PHY symbols, receive FSM state encoding and default lock depth.
package phy_pkg;
   localparam logic [7:0] COM_SYM        = 8'hBC;
   localparam logic [7:0] IDL_SYM        = 8'h7C;
   localparam int         LOCK_COUNT_DEF = 4;

   typedef enum logic [1:0] {
      SEARCH = 2'b00,
      ALIGN  = 2'b01,
      LOCKED = 2'b10
   } state_t;

   // Payload bytes are everything except the framing symbols.
   function automatic logic is_payload(input logic [7:0] b,
                                       input logic [7:0] com,
                                       input logic [7:0] idl);
      return (b != com) && (b != idl);
   endfunction
endpackage

// File: rtl/rx_shift8.sv
// Serial-in shift register plus 3-bit byte boundary counter; sr_n is combinational.
// No backpressure: one bit is consumed every clock.
module rx_shift8 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_data,
   input  logic       i_clr,
   output logic [7:0] o_sr_n,
   output logic       o_boundary
);
   logic [7:0] r_sr;
   logic [2:0] r_bit_cnt;

   assign o_sr_n     = {r_sr[6:0], i_data};
   assign o_boundary = (r_bit_cnt == 3'd7);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sr      <= 8'd0;
         r_bit_cnt <= 3'd0;
      end else begin
         r_sr      <= o_sr_n;
         r_bit_cnt <= i_clr ? 3'd0 : r_bit_cnt + 3'd1;
      end
   end
endmodule

// File: rtl/rx_serial_align.sv
// COM-hunting serial-to-parallel aligner: one byte per 8 clocks, 8-clock latency, no backpressure.
// Optional RX_RESYNC_EN: two consecutive misaligned COMs while locked force a realign.
module rx_serial_align
   import phy_pkg::*;
#(
   parameter logic [7:0] COM        = COM_SYM,
   parameter logic [7:0] IDL        = IDL_SYM,
   parameter int         LOCK_COUNT = LOCK_COUNT_DEF
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       byte_strobe,
   output logic       active
);
   localparam logic [3:0] LC = 4'(LOCK_COUNT);

   state_t     r_state, w_state_n;
   logic [3:0] r_com_cnt, w_com_cnt_n;
   logic [7:0] r_data, w_data_n;
   logic       r_valid, w_valid_n;
   logic       r_strobe, w_strobe_n;
   logic       r_active, w_active_n;
   logic       w_clr;
   logic [7:0] w_sr_n;
   logic       w_boundary;
   logic       w_is_com;
`ifdef RX_RESYNC_EN
   logic       r_mis, w_mis_n;
`endif

   rx_shift8 u_shift (
      .i_clk      (clk_32f),
      .i_rst_n    (reset),
      .i_data     (data_in),
      .i_clr      (w_clr),
      .o_sr_n     (w_sr_n),
      .o_boundary (w_boundary)
   );

   assign w_is_com = (w_sr_n == COM);

   always_comb begin
      w_state_n   = r_state;
      w_com_cnt_n = r_com_cnt;
      w_data_n    = r_data;
      w_valid_n   = r_valid;
      w_active_n  = r_active;
      w_strobe_n  = 1'b0;
      w_clr       = 1'b0;
`ifdef RX_RESYNC_EN
      w_mis_n     = r_mis;
`endif
      case (r_state)
         SEARCH: begin
            if (w_is_com) begin
               w_clr       = 1'b1;
               w_com_cnt_n = 4'd1;
               if (LC == 4'd1) begin
                  w_state_n  = LOCKED;
                  w_active_n = 1'b1;
               end else begin
                  w_state_n = ALIGN;
               end
            end
         end
         ALIGN: begin
            if (w_boundary) begin
               if (w_is_com) begin
                  w_com_cnt_n = r_com_cnt + 4'd1;
                  if ((r_com_cnt + 4'd1) == LC) begin
                     w_state_n  = LOCKED;
                     w_active_n = 1'b1;
                  end
               end else begin
                  w_com_cnt_n = 4'd0;
                  w_state_n   = SEARCH;
               end
            end
         end
         LOCKED: begin
            if (w_boundary) begin
               w_strobe_n = 1'b1;
               if (is_payload(w_sr_n, COM, IDL)) begin
                  w_data_n  = w_sr_n;
                  w_valid_n = 1'b1;
               end else begin
                  w_valid_n = 1'b0;
               end
`ifdef RX_RESYNC_EN
               // An aligned COM proves the framing, so forget any stray match.
               if (w_is_com) w_mis_n = 1'b0;
            end else if (w_is_com) begin
               if (r_mis) begin
                  w_mis_n     = 1'b0;
                  w_active_n  = 1'b0;
                  w_valid_n   = 1'b0;
                  w_clr       = 1'b1;
                  w_com_cnt_n = 4'd1;
                  w_state_n   = ALIGN;
               end else begin
                  w_mis_n = 1'b1;
               end
`endif
            end
         end
         default: w_state_n = SEARCH;
      endcase
   end

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         r_state   <= SEARCH;
         r_com_cnt <= 4'd0;
         r_data    <= 8'd0;
         r_valid   <= 1'b0;
         r_strobe  <= 1'b0;
         r_active  <= 1'b0;
`ifdef RX_RESYNC_EN
         r_mis     <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_n;
         r_com_cnt <= w_com_cnt_n;
         r_data    <= w_data_n;
         r_valid   <= w_valid_n;
         r_strobe  <= w_strobe_n;
         r_active  <= w_active_n;
`ifdef RX_RESYNC_EN
         r_mis     <= w_mis_n;
`endif
      end
   end

   assign data_out    = r_data;
   assign valid_out   = r_valid;
   assign byte_strobe = r_strobe;
   assign active      = r_active;
endmodule

// File: tb/tb_rx_serial_align.sv
// Directed bench for rx_serial_align with a payload scoreboard and strobe-period tracking.
module tb_rx_serial_align;
   localparam logic [7:0] COM = 8'hBC;
   localparam logic [7:0] IDL = 8'h7C;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b0;
   logic       data_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       byte_strobe;
   logic       active;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] sb_q[$];
   bit         sb_ign  = 1'b0;
   int         gap     = 0;
   bit         have_prev = 1'b0;

   always #5 clk_32f = ~clk_32f;

   rx_serial_align dut (
      .clk_32f     (clk_32f),
      .reset       (reset),
      .data_in     (data_in),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .byte_strobe (byte_strobe),
      .active      (active)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one bit, then sample 1 time unit after the rising edge.
   task automatic send_bit(input logic b);
      logic [7:0] e;
      @(negedge clk_32f);
      data_in = b;
      @(posedge clk_32f);
      #1;
      gap++;
      if (active !== 1'b1) have_prev = 1'b0;
      if (byte_strobe === 1'b1) begin
         check("strobe_needs_active", {7'd0, active}, 8'd1);
         if (have_prev) check("strobe_period", 8'(gap), 8'd8);
         have_prev = 1'b1;
         gap       = 0;
         if (valid_out === 1'b1 && !sb_ign) begin
            if (sb_q.size() == 0) begin
               check("unexpected_payload", {7'd0, valid_out}, 8'd0);
            end else begin
               e = sb_q.pop_front();
               check("payload", data_out, e);
            end
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit exp);
      if (exp) sb_q.push_back(b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic do_reset();
      @(negedge clk_32f);
      reset   = 1'b0;
      data_in = 1'b0;
      @(negedge clk_32f);
      reset = 1'b1;
   endtask

   initial begin
      reset   = 1'b0;
      data_in = 1'b0;
      repeat (3) @(posedge clk_32f);
      #1;
      check("rst_data_out", data_out, 8'h00);
      check("rst_valid", {7'd0, valid_out}, 8'd0);
      check("rst_strobe", {7'd0, byte_strobe}, 8'd0);
      check("rst_active", {7'd0, active}, 8'd0);
      @(negedge clk_32f);
      reset = 1'b1;

      // Basic lock, first payload bytes
      repeat (3) send_byte(COM, 1'b0);
      check("t1_active_pre", {7'd0, active}, 8'd0);
      send_byte(COM, 1'b0);
      check("t1_active", {7'd0, active}, 8'd1);
      check("t1_no_strobe_on_lock_com", {7'd0, byte_strobe}, 8'd0);
      send_byte(8'h12, 1'b1);
      check("t1_valid_12", {7'd0, valid_out}, 8'd1);
      send_byte(8'h34, 1'b1);
      check("t1_data_34", data_out, 8'h34);

      // Broken COM run falls back to search, then relocks
      do_reset();
      repeat (3) send_byte(COM, 1'b0);
      send_byte(8'h55, 1'b0);
      check("t2_active_after_55", {7'd0, active}, 8'd0);
      check("t2_strobe_after_55", {7'd0, byte_strobe}, 8'd0);
      repeat (3) send_byte(COM, 1'b0);
      check("t2_active_3com", {7'd0, active}, 8'd0);
      send_byte(COM, 1'b0);
      check("t2_relock", {7'd0, active}, 8'd1);
      send_byte(8'h5A, 1'b1);

      // Lock at a bit-shifted position
      do_reset();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      repeat (4) send_byte(COM, 1'b0);
      check("t3_active", {7'd0, active}, 8'd1);
      send_byte(8'hA5, 1'b1);
      check("t3_data_a5", data_out, 8'hA5);

      // COM/IDL filtering while locked
      send_byte(COM, 1'b0);
      check("t4_com_valid", {7'd0, valid_out}, 8'd0);
      check("t4_com_hold", data_out, 8'hA5);
      check("t4_com_strobe", {7'd0, byte_strobe}, 8'd1);
      send_byte(IDL, 1'b0);
      check("t4_idl_valid", {7'd0, valid_out}, 8'd0);
      check("t4_idl_hold", data_out, 8'hA5);
      send_byte(IDL, 1'b0);
      check("t4_idl2_valid", {7'd0, valid_out}, 8'd0);
      send_byte(8'h01, 1'b1);
      check("t4_valid_01", {7'd0, valid_out}, 8'd1);
      check("t4_data_01", data_out, 8'h01);

      // Asynchronous reset mid-byte while locked
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("t5_async_active", {7'd0, active}, 8'd0);
      check("t5_async_data", data_out, 8'h00);
      check("t5_async_valid", {7'd0, valid_out}, 8'd0);
      check("t5_async_strobe", {7'd0, byte_strobe}, 8'd0);
      data_in = 1'b0;
      @(negedge clk_32f);
      reset = 1'b1;
      send_byte(8'h77, 1'b0);
      check("t5_no_strobe", {7'd0, byte_strobe}, 8'd0);
      repeat (3) send_byte(COM, 1'b0);
      check("t5_active_3com", {7'd0, active}, 8'd0);
      send_byte(COM, 1'b0);
      check("t5_relock", {7'd0, active}, 8'd1);
      send_byte(8'h99, 1'b1);
      check("t5_data_99", data_out, 8'h99);

      // 3-bit slip followed by COMs
      sb_ign = 1'b1;
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
      send_byte(COM, 1'b0);
      send_byte(COM, 1'b0);
`ifdef RX_RESYNC_EN
      check("t6_active_drop", {7'd0, active}, 8'd0);
      check("t6_valid_drop", {7'd0, valid_out}, 8'd0);
      repeat (3) send_byte(COM, 1'b0);
      check("t6_relock", {7'd0, active}, 8'd1);
      sb_ign = 1'b0;
      send_byte(8'h42, 1'b1);
      check("t6_data_42", data_out, 8'h42);
`else
      check("t6_active_kept", {7'd0, active}, 8'd1);
      repeat (3) send_byte(COM, 1'b0);
      send_byte(8'h42, 1'b0);
      check("t6_active_still", {7'd0, active}, 8'd1);
`endif

      check("sb_drain", 8'(sb_q.size()), 8'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
